kmeans_pass_ctrl: RTL

Sequencer and single-port memory scheduler for the k-means engine. It owns the 4096x16 point SRAM port. It loads the streamed points into the SRAM, then replays the full point set once per iteration to the grouping/accumulate datapath, and hands off to the centroid update. It counts iterations, stops on convergence or on an iteration limit, and pulses completion to the output stage.

---
 rtl/kmeans_pass_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/kmeans_pass_ctrl.sv
// rtl/kmeans_pass_ctrl.sv - k-means load/sweep sequencer and point SRAM port scheduler
// Optional iteration limit and timeout reporting enabled by `define KMEANS_ITER_LIMIT_EN.
module kmeans_pass_ctrl #(
  parameter int DATA_SIZE = 4096,
  parameter int ADDR_W    = 12,
  parameter int RD_LAT    = 2,
  parameter int MAX_ITER  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load_valid,
  input  logic [15:0]       load_data,
  input  logic              upd_ack,
  input  logic              upd_conv,
  output logic [ADDR_W-1:0] mem_a,
  output logic [15:0]       mem_di,
  output logic              mem_web,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              sweep_done,
  output logic [7:0]        iter_cnt,
  output logic              done,
  output logic              timeout,
  output logic              busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_SWEEP    = 3'd2;
  localparam logic [2:0] S_DRAIN    = 3'd3;
  localparam logic [2:0] S_WAIT_UPD = 3'd4;
  localparam logic [2:0] S_FINISH   = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DATA_SIZE - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [7:0]        ITER_LIMIT = 8'(MAX_ITER);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_cnt;
  logic              iss_v;
  logic              iss_l;
  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_l;
  logic              stop_lim;
  logic              limit_en;

  logic [7:0]        iter_nxt;
  logic              limit_hit;
  logic              upd_stop;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue_last;

`ifdef KMEANS_ITER_LIMIT_EN
  assign limit_en = 1'b1;
`else
  assign limit_en = 1'b0;
`endif

  // A sweep restart issues address 0 straight from WAIT_UPD so it lands on mem_a one cycle after upd_ack.
  always_comb begin
    iter_nxt   = (iter_cnt == 8'hFF) ? 8'hFF : iter_cnt + 8'd1;
    limit_hit  = limit_en && (iter_nxt == ITER_LIMIT);
    upd_stop   = upd_conv || limit_hit;
    issue_en   = !clr && ((state == S_SWEEP) ||
                          (state == S_WAIT_UPD && upd_ack && !upd_stop));
    issue_addr = (state == S_SWEEP) ? addr_cnt : '0;
    issue_last = (issue_addr == LAST_ADDR);
  end

  assign rd_valid = pipe_v[RD_LAT-1];
  assign rd_last  = pipe_l[RD_LAT-1];
  assign busy     = (state != S_IDLE) || done;

  // Tag pipeline: iss_* aligns with mem_a, then RD_LAT stages to the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_v  <= 1'b0;
      iss_l  <= 1'b0;
      pipe_v <= '0;
      pipe_l <= '0;
    end else if (clr) begin
      iss_v  <= 1'b0;
      iss_l  <= 1'b0;
      pipe_v <= '0;
      pipe_l <= '0;
    end else begin
      iss_v     <= issue_en;
      iss_l     <= issue_en && issue_last;
      pipe_v[0] <= iss_v;
      pipe_l[0] <= iss_l;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_l[i] <= pipe_l[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr_cnt   <= '0;
      mem_a      <= '0;
      mem_di     <= '0;
      mem_web    <= 1'b1;
      sweep_done <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      iter_cnt   <= '0;
      stop_lim   <= 1'b0;
    end else begin
      mem_web    <= 1'b1;
      sweep_done <= 1'b0;
      done       <= 1'b0;
      if (clr) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (load_valid) begin
              mem_a    <= '0;
              mem_di   <= load_data;
              mem_web  <= 1'b0;
              iter_cnt <= '0;
              timeout  <= 1'b0;
              if (LAST_ADDR == '0) begin
                addr_cnt <= '0;
                state    <= S_SWEEP;
              end else begin
                addr_cnt <= ADDR_ONE;
                state    <= S_LOAD;
              end
            end
          end
          S_LOAD: begin
            if (load_valid) begin
              mem_a   <= addr_cnt;
              mem_di  <= load_data;
              mem_web <= 1'b0;
              // Terminal count is compared, never detected by wrap, so DATA_SIZE == 2^ADDR_W works.
              if (addr_cnt == LAST_ADDR) begin
                addr_cnt <= '0;
                state    <= S_SWEEP;
              end else begin
                addr_cnt <= addr_cnt + ADDR_ONE;
              end
            end
          end
          S_SWEEP: begin
            mem_a    <= issue_addr;
            addr_cnt <= issue_addr + ADDR_ONE;
            if (issue_last) state <= S_DRAIN;
          end
          S_DRAIN: begin
            if (rd_last) begin
              sweep_done <= 1'b1;
              state      <= S_WAIT_UPD;
            end
          end
          S_WAIT_UPD: begin
            if (upd_ack) begin
              iter_cnt <= iter_nxt;
              stop_lim <= limit_hit && !upd_conv;
              if (upd_stop) begin
                state <= S_FINISH;
              end else begin
                mem_a    <= issue_addr;
                addr_cnt <= issue_addr + ADDR_ONE;
                state    <= issue_last ? S_DRAIN : S_SWEEP;
              end
            end
          end
          S_FINISH: begin
            done    <= 1'b1;
            timeout <= stop_lim;
            state   <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
